// File: rtl/jtoutrun_obj_scan.sv
// jtoutrun_obj_scan: walks the object table once per line and hands every
// entry that covers the line being prepared to the draw engine.
// The CPU and the scanner each own one table buffer; 'half' picks the CPU
// buffer and the swap takes effect at the start of vertical blank.
// Optional feature macro: JTOUTRUN_OBJ_CLR_EN, which clears the scanner
// buffer (end marker into word 0 of every entry) when vblank ends.
module jtoutrun_obj_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        lvbl,
  input  logic [8:0]  vrender,
  input  logic        swap_req,
  output logic        half,
  output logic [9:0]  tbl_addr,
  input  logic [15:0] tbl_dout,
  output logic        tbl_we,
  output logic [15:0] tbl_din,
  output logic        dr_start,
  input  logic        dr_busy,
  output logic [8:0]  dr_row,
  output logic [15:0] dr_xpos,
  output logic [15:0] dr_addr,
  output logic [15:0] dr_attr
);

`ifdef JTOUTRUN_OBJ_CLR_EN
  typedef enum logic [3:0] {IDLE, RD0, RD1, CHK, RD2, RD3, RD4, REQ, NEXT, CLR} state_t;
`else
  typedef enum logic [3:0] {IDLE, RD0, RD1, CHK, RD2, RD3, RD4, REQ, NEXT} state_t;
`endif

  state_t      state, state_nxt;
  logic        hs_l, lvbl_l;
  logic        hs_rise, lvbl_fall;
  logic        start_scan;
  logic [8:0]  line;
  logic [6:0]  entry;
  logic        end_q, hide_q;
  logic [8:0]  top_q;
  logic        in_range, visible, last_entry;
  logic        swap_pend;

  // The address register always runs one word ahead of the data being
  // captured, so tbl_dout for the word addressed in one cycle is sampled at
  // the end of the following cycle. Word 1 is consumed straight off the bus
  // in CHK, where it arrives, so no extra state is needed for the compare.
  assign hs_rise    = hs & ~hs_l;
  assign lvbl_fall  = ~lvbl & lvbl_l;
  assign last_entry = (entry == 7'd127);
  assign in_range   = (line >= top_q) && (line <= tbl_dout[8:0]);
  assign visible    = ~hide_q & in_range;

`ifdef JTOUTRUN_OBJ_CLR_EN
  logic clr_start;
  // A clear starting in the same clk as a line strobe wins; that strobe is lost.
  assign clr_start  = (state == IDLE) && lvbl && !lvbl_l;
  assign start_scan = hs_rise && (state != CLR) && !clr_start &&
                      ((state != IDLE) || lvbl);
`else
  assign start_scan = hs_rise && ((state != IDLE) || lvbl);
`endif

  // Edge detectors for the line strobe and the blanking signal
  always_ff @(posedge clk) begin
    hs_l   <= hs;
    lvbl_l <= lvbl;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a line strobe outside IDLE restarts the scan at entry 0
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef JTOUTRUN_OBJ_CLR_EN
        if (clr_start) state_nxt = CLR;
`endif
      end
      RD0:  state_nxt = RD1;
      RD1:  state_nxt = CHK;
      CHK: begin
        if (end_q)         state_nxt = IDLE;
        else if (!visible) state_nxt = NEXT;
        else               state_nxt = RD2;
      end
      RD2:  state_nxt = RD3;
      RD3:  state_nxt = RD4;
      RD4:  state_nxt = REQ;
      REQ:  if (!dr_busy) state_nxt = NEXT;
      NEXT: state_nxt = last_entry ? IDLE : RD0;
`ifdef JTOUTRUN_OBJ_CLR_EN
      CLR:  if (last_entry) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (start_scan) state_nxt = RD0;
  end

  // Table walk datapath: address sequencing, entry capture and draw request
  always_ff @(posedge clk) begin
    if (rst) begin
      line     <= 9'd0;
      entry    <= 7'd0;
      end_q    <= 1'b0;
      hide_q   <= 1'b0;
      top_q    <= 9'd0;
      tbl_addr <= 10'd0;
      dr_start <= 1'b0;
      dr_row   <= 9'd0;
      dr_xpos  <= 16'd0;
      dr_addr  <= 16'd0;
      dr_attr  <= 16'd0;
    end else begin
      dr_start <= 1'b0;
      if (start_scan) begin
        line     <= vrender;
        entry    <= 7'd0;
        tbl_addr <= 10'd0;
      end else begin
        case (state)
`ifdef JTOUTRUN_OBJ_CLR_EN
          IDLE: begin
            if (clr_start) begin
              entry    <= 7'd0;
              tbl_addr <= 10'd0;
            end
          end
          CLR: begin
            if (!last_entry) begin
              entry    <= entry + 7'd1;
              tbl_addr <= {entry + 7'd1, 3'd0};
            end
          end
`endif
          RD0: tbl_addr <= {entry, 3'd1};
          RD1: begin
            tbl_addr <= {entry, 3'd2};
            end_q    <= tbl_dout[15];
            hide_q   <= tbl_dout[14];
            top_q    <= tbl_dout[8:0];
          end
          CHK: begin
            if (!end_q && visible) begin
              tbl_addr <= {entry, 3'd3};
              dr_row   <= line - top_q;
            end
          end
          RD2: begin
            tbl_addr <= {entry, 3'd4};
            dr_xpos  <= tbl_dout;
          end
          RD3: dr_addr <= tbl_dout;
          RD4: dr_attr <= tbl_dout;
          REQ: if (!dr_busy) dr_start <= 1'b1;
          NEXT: begin
            if (!last_entry) begin
              entry    <= entry + 7'd1;
              tbl_addr <= {entry + 7'd1, 3'd0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Buffer swap: a request waits for the next vblank start, or swaps right
  // away if it arrives in the same clk as that edge
  always_ff @(posedge clk) begin
    if (rst) begin
      half      <= 1'b0;
      swap_pend <= 1'b0;
    end else if (lvbl_fall && (swap_pend || swap_req)) begin
      half      <= ~half;
      swap_pend <= 1'b0;
    end else if (swap_req) begin
      swap_pend <= 1'b1;
    end
  end

`ifdef JTOUTRUN_OBJ_CLR_EN
  // Write strobe follows the state being entered so it lines up with tbl_addr
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_we  <= 1'b0;
      tbl_din <= 16'h0000;
    end else begin
      tbl_we  <= (state_nxt == CLR);
      tbl_din <= (state_nxt == CLR) ? 16'h8000 : 16'h0000;
    end
  end
`else
  assign tbl_we  = 1'b0;
  assign tbl_din = 16'h0000;
`endif

endmodule

// File: tb/tb_jtoutrun_obj_scan.sv
// Directed testbench for jtoutrun_obj_scan: table read model, draw request
// counting, buffer swap and (with JTOUTRUN_OBJ_CLR_EN) the vblank clear.
module tb_jtoutrun_obj_scan;

  logic        clk;
  logic        rst;
  logic        hs;
  logic        lvbl;
  logic [8:0]  vrender;
  logic        swap_req;
  logic        half;
  logic [9:0]  tbl_addr;
  logic [15:0] tbl_dout;
  logic        tbl_we;
  logic [15:0] tbl_din;
  logic        dr_start;
  logic        dr_busy;
  logic [8:0]  dr_row;
  logic [15:0] dr_xpos;
  logic [15:0] dr_addr;
  logic [15:0] dr_attr;

  logic [15:0] mem [0:1023];
  int          tests = 0;
  int          failures = 0;
  int          start_cnt = 0;
  logic [9:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];

  jtoutrun_obj_scan dut (
    .clk      (clk),
    .rst      (rst),
    .hs       (hs),
    .lvbl     (lvbl),
    .vrender  (vrender),
    .swap_req (swap_req),
    .half     (half),
    .tbl_addr (tbl_addr),
    .tbl_dout (tbl_dout),
    .tbl_we   (tbl_we),
    .tbl_din  (tbl_din),
    .dr_start (dr_start),
    .dr_busy  (dr_busy),
    .dr_row   (dr_row),
    .dr_xpos  (dr_xpos),
    .dr_addr  (dr_addr),
    .dr_attr  (dr_attr)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous table RAM: data for an address shows up one clk later
  initial tbl_dout = 16'h0000;
  always @(posedge clk) tbl_dout <= mem[tbl_addr];

  // Event monitor: counts draw requests and logs table writes just after each edge
  always @(posedge clk) begin
    #1;
    if (dr_start) start_cnt++;
    if (tbl_we) begin
      wr_addr_q.push_back(tbl_addr);
      wr_data_q.push_back(tbl_din);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Line strobe carrying the line number to prepare
  task automatic applyStimulus(input logic [8:0] line);
    vrender = line;
    hs = 1'b1;
    @(negedge clk);
    hs = 1'b0;
  endtask

  task automatic initTable();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int e = 0; e < 128; e++) mem[e*8] = 16'h8000;
  endtask

  task automatic setEntry(input int idx, input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
    mem[idx*8+0] = w0;
    mem[idx*8+1] = w1;
    mem[idx*8+2] = w2;
    mem[idx*8+3] = w3;
    mem[idx*8+4] = w4;
  endtask

  task automatic waitStarts(input string tag, input int target, input int budget);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, start_cnt, target);
  endtask

  initial begin
    int base;
    int qbase;
    int n;
    rst = 1'b1; hs = 1'b0; lvbl = 1'b1; vrender = 9'd0;
    swap_req = 1'b0; dr_busy = 1'b0;
    initTable();
    repeat (4) @(negedge clk);

    // Reset values
    checkOutput("rst_half", half, 0);
    checkOutput("rst_tbl_addr", tbl_addr, 0);
    checkOutput("rst_tbl_we", tbl_we, 0);
    checkOutput("rst_tbl_din", tbl_din, 0);
    checkOutput("rst_dr_start", dr_start, 0);
    checkOutput("rst_dr_row", dr_row, 0);
    checkOutput("rst_dr_xpos", dr_xpos, 0);
    checkOutput("rst_dr_addr", dr_addr, 0);
    checkOutput("rst_dr_attr", dr_attr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // One visible entry, the next one just misses (line 15 is above top 16)
    setEntry(0, 16'd10, 16'd20, 16'h1234, 16'hABCD, 16'h5A5A);
    setEntry(1, 16'd16, 16'd30, 16'h9999, 16'h9999, 16'h9999);
    base = start_cnt;
    applyStimulus(9'd15);
    waitStarts("s1_start", base + 1, 40);
    checkOutput("s1_pulse_hi", dr_start, 1);
    checkOutput("s1_row", dr_row, 5);
    checkOutput("s1_xpos", dr_xpos, 16'h1234);
    checkOutput("s1_addr", dr_addr, 16'hABCD);
    checkOutput("s1_attr", dr_attr, 16'h5A5A);
    @(negedge clk);
    checkOutput("s1_pulse_lo", dr_start, 0);
    repeat (30) @(negedge clk);
    checkOutput("s1_single", start_cnt, base + 1);
    checkOutput("s1_stop_addr", tbl_addr, 10'd18);

    // End marker on entry 0 stops the scan before the visible entry 1
    initTable();
    setEntry(0, 16'h8000 | 16'd10, 16'd20, 16'h7777, 16'h7777, 16'h7777);
    setEntry(1, 16'd0, 16'd511, 16'h7777, 16'h7777, 16'h7777);
    base = start_cnt;
    applyStimulus(9'd15);
    repeat (30) @(negedge clk);
    checkOutput("s2_no_start", start_cnt, base);
    checkOutput("s2_idle_addr", tbl_addr, 10'd2);

    // Draw engine busy: second request waits, dr_* hold steady
    initTable();
    setEntry(0, 16'd30, 16'd100, 16'h1111, 16'h1112, 16'h1113);
    setEntry(1, 16'd20, 16'd30, 16'h2222, 16'h2223, 16'h2224);
    base = start_cnt;
    applyStimulus(9'd30);
    waitStarts("s3_first", base + 1, 40);
    checkOutput("s3_row0", dr_row, 0);
    checkOutput("s3_xpos0", dr_xpos, 16'h1111);
    dr_busy = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("s3_wait20", start_cnt, base + 1);
    checkOutput("s3_row1", dr_row, 10);
    checkOutput("s3_xpos1", dr_xpos, 16'h2222);
    repeat (30) @(negedge clk);
    checkOutput("s3_wait50", start_cnt, base + 1);
    checkOutput("s3_row_stable", dr_row, 10);
    checkOutput("s3_xpos_stable", dr_xpos, 16'h2222);
    checkOutput("s3_addr_stable", dr_addr, 16'h2223);
    checkOutput("s3_attr_stable", dr_attr, 16'h2224);
    dr_busy = 1'b0;
    waitStarts("s3_second", base + 2, 5);
    repeat (30) @(negedge clk);
    checkOutput("s3_total", start_cnt, base + 2);
    checkOutput("s3_stop_addr", tbl_addr, 10'd18);

    // New line strobe while entry 5 is being read aborts and restarts
    initTable();
    for (int e = 0; e < 5; e++) setEntry(e, 16'h4000, 16'd511, 16'h0, 16'h0, 16'h0);
    setEntry(5, 16'd50, 16'd60, 16'h5555, 16'h5556, 16'h5557);
    base = start_cnt;
    applyStimulus(9'd55);
    n = 0;
    while (tbl_addr !== 10'd43 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("s4_reach_e5", tbl_addr, 10'd43);
    applyStimulus(9'd200);
    checkOutput("s4_restart_addr", tbl_addr, 10'd0);
    repeat (80) @(negedge clk);
    checkOutput("s4_no_start", start_cnt, base);
    checkOutput("s4_rescan_done", tbl_addr, 10'd50);

    // Buffer swap on vblank start
    checkOutput("s5_half0", half, 0);
    swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
    @(negedge clk);
    swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("s5_hold", half, 0);
    qbase = wr_addr_q.size();
    lvbl = 1'b0;
    @(negedge clk);
    checkOutput("s5_toggle", half, 1);
    repeat (10) @(negedge clk);
    checkOutput("s5_once", half, 1);
    lvbl = 1'b1;
    repeat (140) @(negedge clk);
`ifdef JTOUTRUN_OBJ_CLR_EN
    checkOutput("s5_clr_count", wr_addr_q.size() - qbase, 128);
    for (int i = 0; i < 128; i++) begin
      if (qbase + i < wr_addr_q.size()) begin
        checkOutput($sformatf("clr_addr%0d", i), wr_addr_q[qbase+i], i*8);
        checkOutput($sformatf("clr_data%0d", i), wr_data_q[qbase+i], 16'h8000);
      end
    end
`else
    checkOutput("s5_no_clr", wr_addr_q.size() - qbase, 0);
`endif
    lvbl = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("s5_no_toggle", half, 1);
    lvbl = 1'b1;
    repeat (140) @(negedge clk);
    swap_req = 1'b1;
    lvbl = 1'b0;
    @(negedge clk);
    swap_req = 1'b0;
    checkOutput("s5_same_clk", half, 0);
    lvbl = 1'b1;
    repeat (140) @(negedge clk);
    lvbl = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("s5_pend_cleared", half, 0);
    lvbl = 1'b1;
    repeat (140) @(negedge clk);

    // Reset while a request waits on the draw engine
    initTable();
    setEntry(0, 16'd0, 16'd100, 16'h6666, 16'h6667, 16'h6668);
    base = start_cnt;
    dr_busy = 1'b1;
    applyStimulus(9'd40);
    repeat (15) @(negedge clk);
    checkOutput("s6_waiting", dr_xpos, 16'h6666);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("s6_rst_xpos", dr_xpos, 0);
    checkOutput("s6_rst_addr", tbl_addr, 0);
    checkOutput("s6_rst_half", half, 0);
    rst = 1'b0;
    dr_busy = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("s6_no_start", start_cnt, base);

`ifndef JTOUTRUN_OBJ_CLR_EN
    checkOutput("no_writes", wr_addr_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
